// File: rtl/traffic_xsection.sv
// traffic_xsection: two-road intersection signal controller.
// Sequences the main road (NS) and the side road (EW) through green,
// yellow and all-red clearance phases with elaboration-time durations.
// Also provides a latched pedestrian request that can shorten NS green,
// a walk indication during EW green, and a night flash mode.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous active-high reset
//   ped_req  - pedestrian button (pulse or level), sampled every cycle
//   flash    - flash-mode request (level)
//   light_ns - NS lamp: 0 RED, 1 YELLOW, 2 GREEN, 3 OFF
//   light_ew - EW lamp, same encoding
//   walk     - pedestrian walk indication
//   phase    - current state code (debug/verification)
module traffic_xsection #(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned NS_GREEN     = 20,
    parameter int unsigned NS_YELLOW    = 5,
    parameter int unsigned EW_GREEN     = 10,
    parameter int unsigned EW_YELLOW    = 5,
    parameter int unsigned ALL_RED      = 2,
    parameter int unsigned NS_MIN_GREEN = 8,
    parameter int unsigned FLASH_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       flash,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NSG = 3'd0,
        S_NSY = 3'd1,
        S_AR1 = 3'd2,
        S_EWG = 3'd3,
        S_EWY = 3'd4,
        S_AR2 = 3'd5,
        S_FLS = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_RED = 2'd0;
    localparam logic [1:0] LAMP_YEL = 2'd1;
    localparam logic [1:0] LAMP_GRN = 2'd2;
    localparam logic [1:0] LAMP_OFF = 2'd3;

    // Last counter value of each timed state (duration D exits at D-1).
    localparam logic [CNT_W-1:0] NSG_LAST = CNT_W'(NS_GREEN - 1);
    localparam logic [CNT_W-1:0] NSY_LAST = CNT_W'(NS_YELLOW - 1);
    localparam logic [CNT_W-1:0] EWG_LAST = CNT_W'(EW_GREEN - 1);
    localparam logic [CNT_W-1:0] EWY_LAST = CNT_W'(EW_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(NS_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLASH_HALF - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             blink_q, blink_d;
    logic [1:0]       light_ns_q, light_ns_d;
    logic [1:0]       light_ew_q, light_ew_d;
    logic             walk_q, walk_d;

    // Next-state, counter, pedestrian latch and blink logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        blink_d    = blink_q;
        ped_pend_d = ped_pend_q | ped_req;

        case (state_q)
            S_NSG: begin
                // A live button press counts as well as a latched one.
                if ((cnt_q == NSG_LAST) ||
                    ((ped_pend_q | ped_req) && (cnt_q >= MIN_LAST))) begin
                    state_d = S_NSY;
                end
            end
            S_NSY: if (cnt_q == NSY_LAST) state_d = S_AR1;
            S_AR1: if (cnt_q == AR_LAST)  state_d = flash ? S_FLS : S_EWG;
            S_EWG: if (cnt_q == EWG_LAST) state_d = S_EWY;
            S_EWY: if (cnt_q == EWY_LAST) state_d = S_AR2;
            S_AR2: if (cnt_q == AR_LAST)  state_d = flash ? S_FLS : S_NSG;
            S_FLS: begin
                // Each half-period restarts the counter; leaving skips the toggle.
                if (cnt_q == FL_LAST) begin
                    cnt_d = '0;
                    if (!flash) begin
                        state_d = S_AR2;
                    end else begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: state_d = S_AR2;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Entering EWG serves the request, including one arriving on that edge.
        if ((state_d == S_EWG) && (state_q != S_EWG)) begin
            ped_pend_d = 1'b0;
        end
    end

    // Lamp decode of the next state so outputs update with the state register.
    always_comb begin
        light_ns_d = LAMP_RED;
        light_ew_d = LAMP_RED;
        walk_d     = 1'b0;
        case (state_d)
            S_NSG: light_ns_d = LAMP_GRN;
            S_NSY: light_ns_d = LAMP_YEL;
            S_EWG: begin
                light_ew_d = LAMP_GRN;
                walk_d     = 1'b1;
            end
            S_EWY: light_ew_d = LAMP_YEL;
            S_FLS: begin
                if (blink_d) begin
                    light_ns_d = LAMP_YEL;
                    light_ew_d = LAMP_RED;
                end else begin
                    light_ns_d = LAMP_OFF;
                    light_ew_d = LAMP_OFF;
                end
            end
            default: begin
                light_ns_d = LAMP_RED;
                light_ew_d = LAMP_RED;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_AR2;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            blink_q    <= 1'b1;
            light_ns_q <= LAMP_RED;
            light_ew_q <= LAMP_RED;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            blink_q    <= blink_d;
            light_ns_q <= light_ns_d;
            light_ew_q <= light_ew_d;
            walk_q     <= walk_d;
        end
    end

    assign light_ns = light_ns_q;
    assign light_ew = light_ew_q;
    assign walk     = walk_q;
    assign phase    = 3'(state_q);

endmodule

// File: tb/tb_traffic_xsection.sv
// Directed bench for traffic_xsection: expected per-cycle outputs and the
// inputs for that cycle are queued, then replayed cycle by cycle.
module tb_traffic_xsection;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] OFF = 2'd3;

    localparam logic [2:0] P_NSG = 3'd0;
    localparam logic [2:0] P_NSY = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_EWG = 3'd3;
    localparam logic [2:0] P_EWY = 3'd4;
    localparam logic [2:0] P_AR2 = 3'd5;
    localparam logic [2:0] P_FLS = 3'd6;

    logic       clk;
    logic       rst;
    logic       ped_req;
    logic       flash;
    logic [1:0] light_ns;
    logic [1:0] light_ew;
    logic       walk;
    logic [2:0] phase;

    typedef struct {
        logic       ped;
        logic       fl;
        logic [7:0] exp;
        string      tag;
    } item_t;

    item_t q[$];
    logic  cur_fl;
    int    total;
    int    bad;

    traffic_xsection dut (
        .clk      (clk),
        .rst      (rst),
        .ped_req  (ped_req),
        .flash    (flash),
        .light_ns (light_ns),
        .light_ew (light_ew),
        .walk     (walk),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] expect_of(input logic [2:0] ph, input logic blk);
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wk;
        ns = RED;
        ew = RED;
        wk = 1'b0;
        case (ph)
            P_NSG: ns = GRN;
            P_NSY: ns = YEL;
            P_EWG: begin ew = GRN; wk = 1'b1; end
            P_EWY: ew = YEL;
            P_FLS: begin
                ns = blk ? YEL : OFF;
                ew = blk ? RED : OFF;
            end
            default: begin ns = RED; ew = RED; end
        endcase
        return {ph, ns, ew, wk};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = {phase, light_ns, light_ew, walk};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got phase/ns/ew/walk=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   tag, got[7:5], got[4:3], got[2:1], got[0],
                   exp[7:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    // ped_idx: -1 none, -2 every cycle, otherwise the segment cycle to press.
    task automatic push(input string tag, input logic [2:0] ph, input logic blk,
                        input int n, input int ped_idx);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.ped = (ped_idx == -2) || (ped_idx == i);
            it.fl  = cur_fl;
            it.exp = expect_of(ph, blk);
            it.tag = $sformatf("%s[%0d]", tag, i);
            q.push_back(it);
        end
    endtask

    task automatic push_cycle(input string tag);
        push({tag, "_nsg"}, P_NSG, 1'b1, 20, -1);
        push({tag, "_nsy"}, P_NSY, 1'b1, 5, -1);
        push({tag, "_ar1"}, P_AR1, 1'b1, 2, -1);
        push({tag, "_ewg"}, P_EWG, 1'b1, 10, -1);
        push({tag, "_ewy"}, P_EWY, 1'b1, 5, -1);
        push({tag, "_ar2"}, P_AR2, 1'b1, 2, -1);
    endtask

    // Check the current cycle, apply that cycle's inputs, advance one clock.
    task automatic drain();
        item_t it;
        while (q.size() > 0) begin
            it = q.pop_front();
            check(it.tag, it.exp);
            ped_req = it.ped;
            flash   = it.fl;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cur_fl  = 1'b0;
        rst     = 1'b0;
        ped_req = 1'b0;
        flash   = 1'b0;

        // Reset: values appear without a clock edge and hold across edges.
        #2 rst = 1'b1;
        #2 check("rst_async", expect_of(P_AR2, 1'b1));
        @(posedge clk);
        #1 check("rst_held", expect_of(P_AR2, 1'b1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run: 2 cycles of AR2, then a 44-cycle period.
        push("t1_start", P_AR2, 1'b1, 2, -1);
        push_cycle("t1");
        drain();

        // Early pedestrian press at NSG cnt=3: NSG lasts 8.
        push("t2_nsg", P_NSG, 1'b1, 8, 3);
        push("t2_nsy", P_NSY, 1'b1, 5, -1);
        push("t2_ar1", P_AR1, 1'b1, 2, -1);
        push("t2_ewg", P_EWG, 1'b1, 10, -1);
        push("t2_ewy", P_EWY, 1'b1, 5, -1);
        push("t2_ar2", P_AR2, 1'b1, 2, -1);

        // Late press at NSG cnt=12: NSG lasts 13 (also proves latch was cleared).
        push("t3_nsg", P_NSG, 1'b1, 13, 12);
        push("t3_nsy", P_NSY, 1'b1, 5, -1);
        push("t3_ar1", P_AR1, 1'b1, 2, -1);
        push("t3_ewg", P_EWG, 1'b1, 10, -1);
        push("t3_ewy", P_EWY, 1'b1, 5, -1);
        push("t3_ar2", P_AR2, 1'b1, 2, -1);
        drain();

        // Press during EWG cnt=4: that EWG unchanged, following NSG lasts 8.
        push("t4_nsg", P_NSG, 1'b1, 20, -1);
        push("t4_nsy", P_NSY, 1'b1, 5, -1);
        push("t4_ar1", P_AR1, 1'b1, 2, -1);
        push("t4_ewg", P_EWG, 1'b1, 10, 4);
        push("t4_ewy", P_EWY, 1'b1, 5, -1);
        push("t4_ar2", P_AR2, 1'b1, 2, -1);
        push("t4_nsg2", P_NSG, 1'b1, 8, -1);
        push("t4_nsy2", P_NSY, 1'b1, 5, -1);
        push("t4_ar12", P_AR1, 1'b1, 2, -1);
        push("t4_ewg2", P_EWG, 1'b1, 10, -1);
        push("t4_ewy2", P_EWY, 1'b1, 5, -1);
        push("t4_ar22", P_AR2, 1'b1, 2, -1);
        drain();

        // Button held continuously: every NSG lasts exactly 8.
        push("t5_nsg", P_NSG, 1'b1, 8, -2);
        push("t5_nsy", P_NSY, 1'b1, 5, -2);
        push("t5_ar1", P_AR1, 1'b1, 2, -2);
        push("t5_ewg", P_EWG, 1'b1, 10, -2);
        push("t5_ewy", P_EWY, 1'b1, 5, -2);
        push("t5_ar2", P_AR2, 1'b1, 2, -2);
        push("t5_nsg2", P_NSG, 1'b1, 8, -2);
        push("t5_nsy2", P_NSY, 1'b1, 5, -1);
        push("t5_ar12", P_AR1, 1'b1, 2, -1);
        push("t5_ewg2", P_EWG, 1'b1, 10, -1);
        push("t5_ewy2", P_EWY, 1'b1, 5, -1);
        push("t5_ar22", P_AR2, 1'b1, 2, -1);
        drain();

        // Flash raised mid-NSG: NSG/NSY/AR1 complete, then flashing.
        push("t6_nsg_a", P_NSG, 1'b1, 5, -1);
        cur_fl = 1'b1;
        push("t6_nsg_b", P_NSG, 1'b1, 15, -1);
        push("t6_nsy", P_NSY, 1'b1, 5, -1);
        push("t6_ar1", P_AR1, 1'b1, 2, -1);
        push("t6_fls_on", P_FLS, 1'b1, 4, -1);
        push("t6_fls_off", P_FLS, 1'b0, 4, -1);
        push("t6_fls_on2a", P_FLS, 1'b1, 1, -1);
        cur_fl = 1'b0;
        push("t6_fls_on2b", P_FLS, 1'b1, 3, -1);
        // Flash toggled inside AR2; only the exit-cycle value counts.
        cur_fl = 1'b1;
        push("t6_ar2_a", P_AR2, 1'b1, 1, -1);
        cur_fl = 1'b0;
        push("t6_ar2_b", P_AR2, 1'b1, 1, -1);
        push("t6_nsg2", P_NSG, 1'b1, 20, -1);
        push("t6_nsy2", P_NSY, 1'b1, 5, -1);
        cur_fl = 1'b1;
        push("t6_ar1_a", P_AR1, 1'b1, 1, -1);
        cur_fl = 1'b0;
        push("t6_ar1_b", P_AR1, 1'b1, 1, -1);
        push("t6_ewg", P_EWG, 1'b1, 4, -1);
        drain();

        // Asynchronous reset in the middle of EWG, between clock edges.
        #2 rst = 1'b1;
        #1 check("t7_rst_async", expect_of(P_AR2, 1'b1));
        @(posedge clk);
        #1 check("t7_rst_held", expect_of(P_AR2, 1'b1));
        @(negedge clk);
        rst     = 1'b0;
        ped_req = 1'b0;
        flash   = 1'b0;
        push("t7_start", P_AR2, 1'b1, 2, -1);
        push_cycle("t7");
        push("t7_nsg_next", P_NSG, 1'b1, 3, -1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
